// File: rtl/datapath_ctrl.sv
// Multi-cycle control unit: fetches and decodes 16-bit instructions and drives the datapath control word.
// Optional feature macro: CU_COND_BRANCH_EN (conditional branches on latched Z/carry flags).
module datapath_ctrl (
    input  logic        clock_50,
    input  logic        clear,
    input  logic [15:0] mem_data,
    input  logic        Z,
    input  logic        Cout,
    output logic [15:0] pc,
    output logic [2:0]  AA,
    output logic [2:0]  BA,
    output logic [2:0]  DA,
    output logic [4:0]  FS,
    output logic [15:0] k,
    output logic        Cin,
    output logic        WR,
    output logic        MW,
    output logic        MA,
    output logic        MD,
    output logic        PS,
    output logic        IR_L,
    output logic [2:0]  state,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_IMM    = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] CLS_ALU_REG = 2'b00;
    localparam logic [1:0] CLS_ALU_IMM = 2'b01;
    localparam logic [1:0] CLS_MEM     = 2'b10;
    localparam logic [1:0] CLS_CTRL    = 2'b11;

    localparam logic [4:0] FN_JMP  = 5'b00000;
    localparam logic [4:0] FN_BZ   = 5'b00001;
    localparam logic [4:0] FN_BC   = 5'b00010;
    localparam logic [4:0] FN_SUB  = 5'b00101;
    localparam logic [4:0] FN_HALT = 5'b11111;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] k_q, k_d;

    logic [1:0]  cls;
    logic [4:0]  fn;
    logic        is_alu;
    logic        is_store;
    logic        branch_taken;

    assign cls      = ir_q[15:14];
    assign fn       = ir_q[13:9];
    assign is_alu   = (cls == CLS_ALU_REG) || (cls == CLS_ALU_IMM);
    assign is_store = fn[0];

`ifdef CU_COND_BRANCH_EN
    logic zf_q, zf_d;
    logic cf_q, cf_d;

    // Flags are sampled only when an ALU instruction retires; branches see the latched copies.
    always_comb begin
        zf_d = zf_q;
        cf_d = cf_q;
        if (state_q == S_EXEC && is_alu) begin
            zf_d = Z;
            cf_d = Cout;
        end
    end

    always_ff @(posedge clock_50 or negedge clear) begin
        if (!clear) begin
            zf_q <= 1'b0;
            cf_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            cf_q <= cf_d;
        end
    end

    assign branch_taken = (cls == CLS_CTRL) &&
                          ((fn == FN_JMP) ||
                           (fn == FN_BZ && zf_q) ||
                           (fn == FN_BC && cf_q));
`else
    logic unused_status;
    assign unused_status = Z ^ Cout;
    assign branch_taken  = (cls == CLS_CTRL) && (fn == FN_JMP);
`endif

    always_ff @(posedge clock_50 or negedge clear) begin
        if (!clear) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_ALU_REG: state_d = S_EXEC;
                    CLS_ALU_IMM: state_d = S_IMM;
                    CLS_MEM:     state_d = S_MEM;
                    default:     state_d = (fn == FN_HALT) ? S_HALT : S_IMM;
                endcase
            end
            S_IMM:    state_d = S_EXEC;
            S_EXEC:   state_d = S_FETCH;
            S_MEM:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // PC, IR and immediate register; pc arithmetic wraps naturally at 16 bits.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        k_d  = k_q;
        case (state_q)
            S_FETCH: begin
                ir_d = mem_data;
                pc_d = pc_q + 16'd1;
            end
            S_IMM: begin
                k_d  = mem_data;
                pc_d = pc_q + 16'd1;
            end
            S_EXEC: begin
                if (branch_taken) begin
                    pc_d = k_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_50 or negedge clear) begin
        if (!clear) begin
            pc_q <= 16'h0000;
            ir_q <= 16'h0000;
            k_q  <= 16'h0000;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            k_q  <= k_d;
        end
    end

    // Control word depends only on registered state, so strobes fall as soon as clear asserts.
    always_comb begin
        AA   = 3'd0;
        BA   = 3'd0;
        DA   = 3'd0;
        FS   = 5'd0;
        Cin  = 1'b0;
        WR   = 1'b0;
        MW   = 1'b0;
        MA   = 1'b0;
        MD   = 1'b0;
        PS   = 1'b0;
        IR_L = 1'b0;
        if (state_q != S_INIT) begin
            AA = ir_q[5:3];
            BA = ir_q[2:0];
            DA = ir_q[8:6];
            FS = fn;
        end
        case (state_q)
            S_FETCH: IR_L = 1'b1;
            S_EXEC: begin
                Cin = (fn == FN_SUB);
                PS  = branch_taken;
                if (is_alu) begin
                    WR = 1'b1;
                    MA = (cls == CLS_ALU_IMM);
                end
            end
            S_MEM: begin
                if (is_store) begin
                    MW = 1'b1;
                end else begin
                    MD = 1'b1;
                    WR = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign pc     = pc_q;
    assign k      = k_q;
    assign state  = state_q;
    assign halted = (state_q == S_HALT);

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Multi-cycle control unit that sequences the 8-register datapath and its ALU. It fetches 16-bit instructions from instruction memory, decodes them and drives the datapath control word: AA, BA, DA, FS, k, Cin, WR, MW, MA, MD, PS and IR_L. It owns the PC, IR, immediate register and latched status flags. It sits between instruction memory and the datapath top level.

## Interface
- No parameters. Word width is fixed at 16 bits; register addresses are fixed at 3 bits.
- clock_50  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- mem_data  in  16  instruction-memory read data at address pc, valid in the same cycle.
- Z  in  1  datapath zero flag for the current ALU result.
- Cout  in  1  datapath carry-out for the current ALU result.
- pc  out  16  instruction-memory address.
- AA, BA, DA  out  3 each  A-read, B-read and write register addresses.
- FS  out  5  ALU function select.
- k  out  16  immediate operand; enters the A operand when MA=1.
- Cin  out  1  ALU carry-in.
- WR  out  1  register-file write enable.
- MW  out  1  data-memory write enable.
- MA  out  1  A-operand mux select: 0 = register, 1 = k.
- MD  out  1  write-back mux select: 0 = ALU, 1 = memory.
- PS  out  1  PC load from k (branch taken).
- IR_L  out  1  IR load strobe.
- state  out  3  current FSM state, for debug.
- halted  out  1  high in HALT.

## Operation
- **Instruction format:** IR[15:14] = class; IR[13:9] = fn; IR[8:6] = DA; IR[5:3] = AA; IR[2:0] = BA.
- **Classes:**
  - 00: ALU register op, FS=fn.
  - 01: ALU immediate op, FS=fn, A operand = next word.
  - 10: memory op. fn[0]=0 is a load (R[DA] ← M[R[AA]]). fn[0]=1 is a store (M[R[AA]] ← R[BA]).
  - 11: control op. fn=00000 is jump; 00001 is branch-if-Z; 00010 is branch-if-carry; 11111 is halt. Every other fn value is a two-word NOP.
- **States** (encoding in parentheses):
  - INIT (0) → FETCH.
  - FETCH (1): IR ← mem_data, pc ← pc+1, IR_L=1 → DECODE.
  - DECODE (2):
    - class 00 → EXEC.
    - class 01 → IMM.
    - class 10 → MEM.
    - class 11 with fn=11111 → HALT.
    - other class 11 → IMM.
  - IMM (3): k ← mem_data, pc ← pc+1 → EXEC.
  - EXEC (4):
    - class 00/01: WR=1, MD=0, MA = class 01.
    - class 11: PS=1 when the jump/branch is taken, and pc ← k at the edge.
    - → FETCH.
  - MEM (5): load drives MD=1, WR=1; store drives MW=1 → FETCH.
  - HALT (6): absorbing; only clear exits.
- **Control outputs:** decoded combinationally from state and IR/k registers only; no path from mem_data, Z or Cout to outputs.
- **Address/function fields:** AA, BA, DA, FS follow IR in every state except INIT. All strobes (WR, MW, PS, IR_L) are 0 outside the states listed above.
- **Cin:** 1 only in EXEC when fn=00101 (subtract).
- **Flags:** Zf ← Z and Cf ← Cout at the end of every class 00/01 EXEC. Branches test Zf/Cf, not the live inputs.
- **pc arithmetic:** modulo 2^16; 16'hFFFF+1 wraps to 0.
- **Reset:** state=INIT; pc, IR, k, Zf, Cf = 0; all outputs 0. Reset asserted mid-instruction aborts it immediately, and WR/MW drop asynchronously.

## Timing
- Latency in cycles:
  - ALU register op: 3 (FETCH, DECODE, EXEC).
  - ALU immediate op: 4.
  - Load/store: 3.
  - Jump/branch: 4, taken or not.
  - Halt: 2, then stall.
- After clear releases: first FETCH on the 2nd rising edge; pc=0 is fetched first.
- WR and MW are each high for exactly one cycle per instruction.
- A register written in EXEC/MEM is readable by the next instruction, whose earliest read is in its DECODE.
- Taken branch: PS=1 in EXEC, and the next FETCH uses pc=k.

## Configuration
- CU_COND_BRANCH_EN:
  - Defined: fn 00001/00010 are conditional branches as above.
  - Undefined: both are two-word NOPs (immediate consumed, PS stays 0). Zf/Cf are not implemented; jump and halt are unaffected.

## Test plan
- **Reset and first fetch:** release clear with mem[0]=16'h0000 -> all outputs 0 during reset; IR_L=1 and pc=0 in the first FETCH; pc=1 in DECODE.
- **Immediate ALU op:** class 01, fn=00010, DA=3, next word 16'h1234 -> 4 cycles; k=16'h1234, MA=1, WR=1, DA=3 in EXEC; pc advances by 2.
- **Load then store:** load DA=2, AA=1 -> MD=1, WR=1 for one cycle. Store AA=1, BA=2 -> MW=1, WR=0.
- **Branch-if-Z:** subtract (fn=00101) with Z=1, then branch-if-Z to 16'h0040 -> Cin=1 in the subtract EXEC; PS=1 in the branch EXEC; next pc=16'h0040. Repeat with Z=0 -> PS=0, and the next pc is the sequential address.
- **Halt:** halt at pc=16'h0007 -> halted=1 after DECODE; pc frozen at 8; no WR/MW/IR_L for 100 cycles; clear returns to INIT.
- **Reset mid-instruction and pc wrap:** assert clear during EXEC of an ALU op -> WR falls without a clock edge. Also run a one-word instruction at pc=16'hFFFF -> pc wraps to 16'h0000.
